seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PW, default 8, pattern register width in bits (4..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin transmission; sampled only in IDLE.
REQ-005 SHALL have port pattern, input, PW, bit pattern to transmit, MSB-first from bit len.
REQ-006 SHALL have port len, input, $clog2(PW), last bit index; bits sent = len+1.
REQ-007 SHALL have port rep, input, 4, extra repetitions of the pattern; present only when SEQ_GEN_REPEAT_EN is defined.
REQ-008 SHALL have port x, output, 1, serial data bit, registered.
REQ-009 SHALL have port x_vld, output, 1, x carries a valid pattern bit this cycle, registered.
REQ-010 SHALL have port busy, output, 1, high from the cycle after start is accepted through the done cycle.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the final bit.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1: SHALL latch pattern, len, rep into internal registers, set bit counter cnt=len, and enter SHIFT on the next edge.
REQ-014 First bit SHALL appear on x with x_vld=1 in the cycle after start is sampled, giving 1-cycle latency.
REQ-015 In SHIFT: x SHALL equal latched_pattern[cnt]; cnt SHALL decrement by 1 per cycle; x_vld SHALL stay high contiguously for the whole pass.
REQ-016 When cnt==0 in SHIFT with no repetitions left: SHALL enter DONE on the next edge.
REQ-017 In DONE: done=1, x_vld=0, x=0 for exactly one cycle, then IDLE.
REQ-018 Whenever x_vld=0: x SHALL be 0.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored, and no request SHALL be queued.
REQ-020 Changes on pattern, len, or rep after acceptance SHALL NOT affect the transmission in progress.
REQ-021 len=0 SHALL send exactly one bit, pattern[0].
REQ-022 Values of len >= PW SHALL be clamped to PW-1 at latch time.
REQ-023 Back-to-back: start held high continuously SHALL begin a new transmission in the cycle after DONE returns to IDLE, leaving a 1-cycle gap between passes.
REQ-024 Unused FSM encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE and x=0, x_vld=0, busy=0, done=0, cnt=0, with priority over start and over any state.
REQ-026 Reset mid-SHIFT SHALL abort the transmission, SHALL NOT produce a done pulse, and SHALL NOT resume the transmission afterwards.

Configuration
REQ-027 Macro SEQ_GEN_REPEAT_EN defined: rep port SHALL exist; pattern SHALL be sent rep+1 times with no gap, reloading cnt=len after each cnt==0, and done SHALL pulse once after the final pass.
REQ-028 Macro SEQ_GEN_REPEAT_EN undefined: rep port and repeat counter SHALL be absent, and exactly one pass SHALL be sent per accepted start.

Verification
REQ-029 Stimulus: reset released, start=1 for one cycle, PW=8, len=3, pattern=8'h0B. Required response: x=1,0,1,1 with x_vld=1 in cycles 1-4; done=1 in cycle 5; busy=1 in cycles 1-5.
REQ-030 Stimulus: len=7, pattern=8'hA5. Required response: x=1,0,1,0,0,1,0,1 over 8 cycles, followed by the done pulse.
REQ-031 Stimulus: len=0, pattern=8'h01. Required response: a single bit x=1, then done in the next cycle.
REQ-032 Stimulus: start pulse re-asserted and pattern changed to 8'hFF during the 2nd bit of the len=3/8'h0B run. Required response: output unchanged (1,0,1,1), exactly one done pulse.
REQ-033 Stimulus: reset asserted during the 3rd bit. Required response: next cycle x=0, x_vld=0, busy=0, done=0; no done pulse; idle until a new start.
REQ-034 Stimulus: with SEQ_GEN_REPEAT_EN, rep=2, len=1, pattern=8'h02. Required response: x=1,0,1,0,1,0 contiguous over 6 cycles, done in cycle 7.

Source files
------------

// File: rtl/seq_gen.sv
// Serial pattern generator: sends pattern[len]..pattern[0] MSB-first on x, then pulses done.
// Optional macro SEQ_GEN_REPEAT_EN adds the rep port for back-to-back repeated passes.
module seq_gen #(
  parameter  int PW = 8,
  localparam int LW = (PW > 1) ? $clog2(PW) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] len,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic [3:0]    rep,
`endif
  output logic          x,
  output logic          x_vld,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [LW-1:0] LMAX = LW'(PW - 1);

  state_t        r_state;
  logic [PW-1:0] r_pat;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic          r_x;
  logic          r_vld;
  logic          r_busy;
  logic          r_done;
`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0]    r_rep;
`endif

  logic [LW-1:0] w_len;
  logic [LW-1:0] w_cnt_dec;

  // Only reachable when PW is not a power of two.
  assign w_len     = (len > LMAX) ? LMAX : len;
  assign w_cnt_dec = r_cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_x    <= 1'b0;
          r_vld  <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            // First bit is driven straight from the input so it lands one cycle after acceptance.
            r_pat   <= pattern;
            r_len   <= w_len;
            r_cnt   <= w_len;
            r_x     <= pattern[w_len];
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            r_rep   <= rep;
`endif
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
`ifdef SEQ_GEN_REPEAT_EN
            if (r_rep != 4'd0) begin
              r_rep <= r_rep - 4'd1;
              r_cnt <= r_len;
              r_x   <= r_pat[r_len];
            end else begin
              r_state <= S_DONE;
              r_x     <= 1'b0;
              r_vld   <= 1'b0;
              r_done  <= 1'b1;
            end
`else
            r_state <= S_DONE;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_cnt <= w_cnt_dec;
            r_x   <= r_pat[w_cnt_dec];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_x     <= 1'b0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_x     <= 1'b0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign x     = r_x;
  assign x_vld = r_vld;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
